// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port RAM.
// Each transfer walks IDLE -> ACC -> DONE -> IDLE (3 cycles, back-to-back capable).
// Request fields are sampled only in IDLE. gnt pulses in the IDLE cycle that captures a
// request, the RAM strobes are active only in ACC, and ack pulses in DONE.
// A read loads the owner's rdata register at the ACC->DONE edge, so the data is valid
// together with ack.
// Handshake: a requester holds req (level) until it sees gnt. It drops req in the next
// cycle unless it wants another transfer. A req still high when the block is back in
// IDLE starts a new transfer.
// Optional feature: define RAM_ARB_P0_PRIO_EN for fixed priority, where port 0 always
// wins contention. The default is round-robin.
module ram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_be,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_be,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    output logic        ram_re,
    output logic        ram_be,
    input  logic [15:0] ram_dout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        last_gnt;   // port granted most recently (0 or 1)
    logic        owner;      // port that owns the transfer in flight
    logic        we_q;
    logic        be_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        any_req;
    logic        win;        // port selected in the current IDLE cycle
    logic        capture;
    logic        in_acc;

    // Pick the winner among the current requesters.
    always_comb begin
        any_req = p0_req | p1_req;
`ifdef RAM_ARB_P0_PRIO_EN
        win = ~p0_req;
`else
        if (p0_req && p1_req) begin
            win = ~last_gnt;
        end else begin
            win = ~p0_req;
        end
`endif
    end

    assign capture = (state == ST_IDLE) && any_req;
    assign in_acc  = (state == ST_ACC);

    // Fixed three-step sequence. IDLE waits for a request.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = any_req ? ST_ACC : ST_IDLE;
            ST_ACC:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register. Reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winner's request fields and remember it for round-robin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
        end else if (capture) begin
            last_gnt <= win;
            owner    <= win;
            we_q     <= win ? p1_we    : p0_we;
            be_q     <= win ? p1_be    : p0_be;
            addr_q   <= win ? p1_addr  : p0_addr;
            wdata_q  <= win ? p1_wdata : p0_wdata;
        end
    end

    // Load the owner's read-data register as a read leaves ACC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_rdata <= 16'h0000;
            p1_rdata <= 16'h0000;
        end else if (in_acc && !we_q) begin
            if (owner) begin
                p1_rdata <= ram_dout;
            end else begin
                p0_rdata <= ram_dout;
            end
        end
    end

    // Handshake pulses. gnt is gated by reset so it stays low while reset is held.
    always_comb begin
        p0_gnt = reset && capture && !win;
        p1_gnt = reset && capture &&  win;
        p0_ack = (state == ST_DONE) && !owner;
        p1_ack = (state == ST_DONE) &&  owner;
    end

    // RAM side. Outputs are driven only in ACC and are held at zero otherwise.
    always_comb begin
        ram_addr = in_acc ? addr_q  : 16'h0000;
        ram_din  = in_acc ? wdata_q : 16'h0000;
        ram_be   = in_acc & be_q;
        ram_we   = in_acc & we_q;
        ram_re   = in_acc & ~we_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed steps followed by randomized request slots. The results
// are compared against a transfer-level model, which holds last-grant, rdata and memory
// contents.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p0_be, p1_req, p1_we, p1_be;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_ack, p1_gnt, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] ram_addr, ram_din, ram_dout;
    logic        ram_we, ram_re, ram_be;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    logic [15:0] exp_mem [256];
    logic [15:0] m_rdata0, m_rdata1;
    int          m_last;
    int          cyc;
    int          obs_gnt_q [$];
    int          obs_cyc_q [$];
    int          exp_order [4];

    // clock / reset
    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
        .ram_be(ram_be), .ram_dout(ram_dout)
    );

    // RAM: 256 words, aliased on the low address byte. Unwritten words read {a, ~a}.
    logic [15:0] ram_mem [256];
    bit   [255:0] ram_valid;
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr[7:0]]   <= ram_din;
            ram_valid[ram_addr[7:0]] <= 1'b1;
        end
    end
    always_comb begin
        ram_dout = ram_valid[ram_addr[7:0]] ? ram_mem[ram_addr[7:0]]
                                            : {ram_addr[7:0], ~ram_addr[7:0]};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Check every output in this cycle at the falling edge, then move to just after the next rising edge.
    task automatic expect_cycle(input string tag, input logic g0, input logic g1,
                                input logic a0, input logic a1, input logic [15:0] ra,
                                input logic [15:0] rd, input logic rwe, input logic rre,
                                input logic rbe);
        @(negedge clk);
        if (p0_gnt) begin obs_gnt_q.push_back(0); obs_cyc_q.push_back(cyc); end
        if (p1_gnt) begin obs_gnt_q.push_back(1); obs_cyc_q.push_back(cyc); end
        chk({tag, ".p0_gnt"}, 16'(p0_gnt), 16'(g0));
        chk({tag, ".p1_gnt"}, 16'(p1_gnt), 16'(g1));
        chk({tag, ".p0_ack"}, 16'(p0_ack), 16'(a0));
        chk({tag, ".p1_ack"}, 16'(p1_ack), 16'(a1));
        chk({tag, ".ram_addr"}, ram_addr, ra);
        chk({tag, ".ram_din"}, ram_din, rd);
        chk({tag, ".ram_we"}, 16'(ram_we), 16'(rwe));
        chk({tag, ".ram_re"}, 16'(ram_re), 16'(rre));
        chk({tag, ".ram_be"}, 16'(ram_be), 16'(rbe));
        chk({tag, ".p0_rdata"}, p0_rdata, m_rdata0);
        chk({tag, ".p1_rdata"}, p1_rdata, m_rdata1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_p0();
        p0_we = 1'($urandom_range(0, 1)); p0_be = 1'($urandom_range(0, 1));
        p0_addr = 16'($urandom); p0_wdata = 16'($urandom);
    endtask

    task automatic rand_p1();
        p1_we = 1'($urandom_range(0, 1)); p1_be = 1'($urandom_range(0, 1));
        p1_addr = 16'($urandom); p1_wdata = 16'($urandom);
    endtask

    // One arbitration slot, starting in an IDLE cycle. The model picks the winner and
    // predicts the whole transfer.
    task automatic run_slot(input string tag, input bit keep_req, input bit scramble);
        int w;
        logic we, be;
        logic [15:0] a, d;
        if (!p0_req && !p1_req) begin
            expect_cycle({tag, ".idle"}, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
            return;
        end
        if (p0_req && p1_req) begin
`ifdef RAM_ARB_P0_PRIO_EN
            w = 0;
`else
            w = (m_last == 0) ? 1 : 0;
`endif
        end else begin
            w = p1_req ? 1 : 0;
        end
        if (w == 0) begin we = p0_we; be = p0_be; a = p0_addr; d = p0_wdata; end
        else        begin we = p1_we; be = p1_be; a = p1_addr; d = p1_wdata; end
        expect_cycle({tag, ".gnt"}, w == 0, w == 1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        m_last = w;
        if (!keep_req) begin
            if (w == 0) p0_req = 1'b0; else p1_req = 1'b0;
        end
        if (scramble) begin rand_p0(); rand_p1(); end
        expect_cycle({tag, ".acc"}, 0, 0, 0, 0, a, d, we, !we, be);
        if (we) exp_mem[a[7:0]] = d;
        else if (w == 0) m_rdata0 = exp_mem[a[7:0]];
        else m_rdata1 = exp_mem[a[7:0]];
        expect_cycle({tag, ".done"}, 0, 0, w == 0, w == 1, 16'h0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = {i[7:0], ~i[7:0]};
`ifdef RAM_ARB_P0_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        m_rdata0 = 16'h0; m_rdata1 = 16'h0; m_last = 1; cyc = 0;
        reset = 1'b0;
        p0_req = 1'b1; p0_we = 0; p0_be = 0; p0_addr = 16'h0; p0_wdata = 16'h0;
        p1_req = 1'b0; p1_we = 0; p1_be = 0; p1_addr = 16'h0; p1_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        // reset: outputs quiet even with a request pending
        expect_cycle("reset", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        p0_req = 1'b0;
        reset = 1'b1;
        run_slot("idle", 0, 0);

        // p1 writes 0xBEEF at 0x0040, then p0 reads it back
        p1_req = 1; p1_we = 1; p1_be = 1; p1_addr = 16'h0040; p1_wdata = 16'hBEEF;
        run_slot("wr_beef", 0, 0);
        p0_req = 1; p0_we = 0; p0_be = 1; p0_addr = 16'h0040; p0_wdata = 16'h0000;
        run_slot("r018", 0, 0);
        chk("r018.rdata_beef", p0_rdata, 16'hBEEF);

        // p1 write leaves p1_rdata untouched
        p1_req = 1; p1_we = 1; p1_be = 0; p1_addr = 16'h1234; p1_wdata = 16'hA5A5;
        run_slot("r019", 0, 0);

        // p0 changes its address right after gnt. The RAM must see only 0x0010.
        p0_req = 1; p0_we = 0; p0_be = 1; p0_addr = 16'h0010; p0_wdata = 16'h0000;
        expect_cycle("r022.gnt", 1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        m_last = 0;
        p0_req = 0; p0_addr = 16'h0020;
        expect_cycle("r022.acc", 0, 0, 0, 0, 16'h0010, 16'h0000, 0, 1, 1);
        m_rdata0 = exp_mem[8'h10];
        expect_cycle("r022.done", 0, 0, 1, 0, 16'h0, 16'h0, 0, 0, 0);

        // reset during ACC of a p0 read: no ack, no rdata update
        p0_req = 1; p0_we = 0; p0_be = 1; p0_addr = 16'h0077; p0_wdata = 16'h0000;
        expect_cycle("r021.gnt", 1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        p0_req = 0;
        reset = 1'b0;
        #1;
        chk("r021.re_drop", 16'(ram_re), 16'h0);
        m_rdata0 = 16'h0; m_rdata1 = 16'h0; m_last = 1;
        expect_cycle("r021.rst", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        reset = 1'b1;
        expect_cycle("r021.idle0", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        expect_cycle("r021.idle1", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);

        // both requests held high for 12 cycles after reset
        obs_gnt_q.delete(); obs_cyc_q.delete();
        p0_req = 1; p0_we = 0; p0_be = 0; p0_addr = 16'h0100; p0_wdata = 16'h0;
        p1_req = 1; p1_we = 0; p1_be = 1; p1_addr = 16'h0201; p1_wdata = 16'h0;
        for (int k = 0; k < 4; k++) run_slot($sformatf("r020.%0d", k), 1, 0);
        p0_req = 0; p1_req = 0;
        chk("r020.count", 16'(obs_gnt_q.size()), 16'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_gnt_q.size()) begin
                chk($sformatf("r020.order%0d", k), 16'(obs_gnt_q[k]), 16'(exp_order[k]));
                if (k > 0) chk($sformatf("r020.gap%0d", k),
                               16'(obs_cyc_q[k] - obs_cyc_q[k-1]), 16'd3);
            end
        end

        // randomized slots
        for (int s = 0; s < 60; s++) begin
            if (!p0_req && $urandom_range(0, 1) == 1) begin p0_req = 1; rand_p0(); end
            if (!p1_req && $urandom_range(0, 1) == 1) begin p1_req = 1; rand_p1(); end
            run_slot($sformatf("rnd%0d", s), $urandom_range(0, 3) == 0, 1'b1);
        end
        p0_req = 0; p1_req = 0;
        run_slot("drain", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
